// File: rtl/fnv_pkg.sv
// Shared types and constants for the FNV-1a I2C hash controller.
package fnv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_DATA,
    S_READ,
    S_IGNORE
  } state_t;

  localparam logic [31:0] FNV_PRIME_32  = 32'h01000193;
  localparam logic [31:0] FNV_OFFSET_32 = 32'h811C9DC5;
  localparam logic [7:0]  CMD_RESET     = 8'h01;
  localparam logic [7:0]  CMD_HASH      = 8'h02;
  localparam logic [7:0]  IDLE_TX_BYTE  = 8'hFF;

  // Digest byte for read-back, MSB first; past the last byte the bus idles high.
  function automatic logic [7:0] digest_byte(input logic [31:0] digest,
                                             input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = digest[31:24];
      3'd1:    b = digest[23:16];
      3'd2:    b = digest[15:8];
      3'd3:    b = digest[7:0];
      default: b = IDLE_TX_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fnv1a_step.sv
// One FNV-1a round, (h ^ b) * 0x01000193, as a shift-add over the prime's set
// bits 0,1,4,7,8,24: one partial product per cycle, result on the done cycle.
module fnv1a_step
  import fnv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic [31:0] hash_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hash_out
);

  logic [31:0] x_q;
  logic [31:0] acc_q;
  logic [31:0] term;
  logic [31:0] sum;
  logic [2:0]  phase_q;
  logic        run_q;

  // Partial product for the current phase; bit 0 of the prime is the initial acc.
  always_comb begin
    term = '0;
    case (phase_q)
      3'd1:    term = x_q << 1;
      3'd2:    term = x_q << 4;
      3'd3:    term = x_q << 7;
      3'd4:    term = x_q << 8;
      3'd5:    term = x_q << 24;
      default: term = '0;
    endcase
  end

  assign sum      = acc_q + term;
  assign busy     = run_q;
  assign done     = run_q && (phase_q == 3'd5);
  // The final add is folded into the output so the caller commits on the done edge.
  assign hash_out = sum;

  // Load x on start, then accumulate one shifted term per cycle through phase 5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      acc_q   <= '0;
      phase_q <= '0;
      run_q   <= 1'b0;
    end else if (run_q) begin
      acc_q <= sum;
      if (phase_q == 3'd5) begin
        run_q   <= 1'b0;
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 3'd1;
      end
    end else if (start) begin
      x_q     <= hash_in ^ {24'h0, byte_in};
      acc_q   <= hash_in ^ {24'h0, byte_in};
      phase_q <= 3'd1;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/fnv_hash_controller.sv
// I2C transaction controller around the FNV-1a step: address/command decode,
// per-byte hash sequencing, byte counter and MSB-first digest read-back.
module fnv_hash_controller
  import fnv_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR     = 7'h2A,
  parameter logic [31:0] OFFSET_BASIS = FNV_OFFSET_32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_start,
  input  logic             evt_stop,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             rx_ack,
  input  logic             tx_req,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             selected,
  output logic [CNT_W-1:0] byte_count,
  output logic [31:0]      hash_out
);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        addr_match;
  logic        cmd_valid;
  logic        read_addr;
  logic        step_start;
  logic        step_busy;
  logic        step_done;
  logic [31:0] step_hash;
  logic [31:0] snap_q;
  logic [2:0]  idx_q;
  logic        snap_pend_q;
  logic        req_held_q;

  assign addr_match = (rx_data[7:1] == DEV_ADDR);
  assign cmd_valid  = (rx_data == CMD_RESET) || (rx_data == CMD_HASH);
  assign read_addr  = accept && (state_q == S_ADDR) && addr_match && rx_data[0];
  // Busy covers the accept cycle as well as the five accumulate cycles.
  assign busy       = step_busy | step_start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, byte handshake and step launch; bus events override any byte.
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    case (state_q)
      S_ADDR, S_CMD, S_IGNORE: rx_ready = 1'b1;
      S_DATA:                  rx_ready = !step_busy;
      default:                 rx_ready = 1'b0;
    endcase
    if (evt_start || evt_stop) rx_ready = 1'b0;
    accept     = rx_valid && rx_ready;
    step_start = accept && (state_q == S_DATA);
    if (accept) begin
      case (state_q)
        S_ADDR: begin
          if (!addr_match)     state_d = S_IGNORE;
          else if (rx_data[0]) state_d = S_READ;
          else                 state_d = S_CMD;
        end
        S_CMD:   state_d = cmd_valid ? S_DATA : S_IGNORE;
        default: state_d = state_q;
      endcase
    end
    if (evt_start) state_d = S_ADDR;
    if (evt_stop)  state_d = S_IDLE;
  end

  fnv1a_step u_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (step_start),
    .byte_in  (rx_data),
    .hash_in  (hash_out),
    .busy     (step_busy),
    .done     (step_done),
    .hash_out (step_hash)
  );

  // ACK level for the last accepted byte and the addressed-device flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ack   <= 1'b0;
      selected <= 1'b0;
    end else begin
      if (evt_start || evt_stop)
        selected <= 1'b0;
      else if (accept && (state_q == S_ADDR) && addr_match)
        selected <= 1'b1;
      if (accept) begin
        case (state_q)
          S_ADDR:  rx_ack <= addr_match;
          S_CMD:   rx_ack <= cmd_valid;
          S_DATA:  rx_ack <= 1'b1;
          default: rx_ack <= 1'b0;
        endcase
      end
    end
  end

  // Committed hash and saturating byte counter; RESET command takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_out   <= OFFSET_BASIS;
      byte_count <= '0;
    end else if (accept && (state_q == S_CMD) && (rx_data == CMD_RESET)) begin
      hash_out   <= OFFSET_BASIS;
      byte_count <= '0;
    end else if (step_done) begin
      hash_out <= step_hash;
      if (byte_count != '1) byte_count <= byte_count + 1'b1;
    end
  end

  // Snapshot and read-back; a read addressed mid-step snapshots at the commit
  // and any tx_req seen before then is held and answered afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= OFFSET_BASIS;
      idx_q       <= '0;
      snap_pend_q <= 1'b0;
      req_held_q  <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= IDLE_TX_BYTE;
    end else begin
      tx_valid <= 1'b0;
      if (evt_start || evt_stop) begin
        snap_pend_q <= 1'b0;
        req_held_q  <= 1'b0;
      end else if (read_addr) begin
        idx_q      <= '0;
        req_held_q <= 1'b0;
        if (step_done) begin
          snap_q      <= step_hash;
          snap_pend_q <= 1'b0;
        end else if (step_busy) begin
          snap_pend_q <= 1'b1;
        end else begin
          snap_q      <= hash_out;
          snap_pend_q <= 1'b0;
        end
      end else begin
        if (snap_pend_q && step_done) begin
          snap_q      <= step_hash;
          snap_pend_q <= 1'b0;
        end
        if (state_q == S_READ) begin
          if ((tx_req || req_held_q) && !snap_pend_q) begin
            tx_valid   <= 1'b1;
            tx_data    <= digest_byte(snap_q, idx_q);
            idx_q      <= (idx_q == 3'd4) ? 3'd4 : idx_q + 3'd1;
            req_held_q <= 1'b0;
          end else if (tx_req) begin
            req_held_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fnv_hash_controller.sv
// Self-checking bench: directed scenarios plus random write/read transactions
// compared against a plain-arithmetic FNV-1a reference model.
module tb_fnv_hash_controller;

  localparam logic [31:0] OFFSET = 32'h811C9DC5;
  typedef logic [7:0] bytes_t[$];

  logic        clk;
  logic        rst_n;
  logic        evt_start;
  logic        evt_stop;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ack;
  logic        tx_req;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        selected;
  logic [15:0] byte_count;
  logic [31:0] hash_out;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned busy_cycles = 0;
  int unsigned tx_pulses = 0;
  logic [31:0] m_hash;
  int unsigned m_count;

  fnv_hash_controller #(
    .DEV_ADDR     (7'h2A),
    .OFFSET_BASIS (32'h811C9DC5),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt_start  (evt_start),
    .evt_stop   (evt_stop),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_ack     (rx_ack),
    .tx_req     (tx_req),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .selected   (selected),
    .byte_count (byte_count),
    .hash_out   (hash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Count busy and tx_valid cycles, sampled mid-low-phase after inputs settle.
  always @(negedge clk) begin
    #2;
    if (busy) busy_cycles++;
    if (tx_valid) tx_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fnv1a_ref(input logic [31:0] h0, input bytes_t msg);
    logic [31:0] h;
    h = h0;
    foreach (msg[i]) h = (h ^ {24'h0, msg[i]}) * 32'h01000193;
    return h;
  endfunction

  task automatic model_write(input logic [7:0] cmd, input bytes_t data);
    if (cmd == 8'h01) begin
      m_hash  = OFFSET;
      m_count = 0;
    end
    m_hash  = fnv1a_ref(m_hash, data);
    m_count = m_count + data.size();
    if (m_count > 65535) m_count = 65535;
  endtask

  task automatic pulse_start;
    @(negedge clk); evt_start = 1'b1;
    @(negedge clk); evt_start = 1'b0;
  endtask

  task automatic pulse_stop;
    @(negedge clk); evt_stop = 1'b1;
    @(negedge clk); evt_stop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    int unsigned waited;
    waited = 0;
    @(negedge clk); rx_valid = 1'b1; rx_data = b; #1;
    while (!rx_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check("rx_accept", {31'h0, rx_ready}, 32'h1);
    @(negedge clk); rx_valid = 1'b0;
    ack = rx_ack;
  endtask

  task automatic read_byte(output logic [7:0] d);
    int unsigned waited;
    waited = 0;
    @(negedge clk); tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    while (!tx_valid && waited < 50) begin
      @(negedge clk); waited++;
    end
    check("tx_valid", {31'h0, tx_valid}, 32'h1);
    d = tx_data;
  endtask

  task automatic wait_idle;
    int unsigned w;
    w = 0;
    #1;
    while (busy && w < 50) begin
      @(negedge clk); #1; w++;
    end
    check("idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic write_txn(input logic [7:0] cmd, input bytes_t data);
    logic ack;
    pulse_start;
    send_byte(8'h54, ack); check("w_addr_ack", {31'h0, ack}, 32'h1);
    send_byte(cmd, ack);   check("w_cmd_ack", {31'h0, ack}, 32'h1);
    foreach (data[i]) begin
      send_byte(data[i], ack); check("w_data_ack", {31'h0, ack}, 32'h1);
    end
    wait_idle;
    pulse_stop;
    model_write(cmd, data);
  endtask

  task automatic read_txn(input bit fifth, output logic [31:0] w);
    logic       ack;
    logic [7:0] d;
    w = '0;
    pulse_start;
    send_byte(8'h55, ack);
    check("r_addr_ack", {31'h0, ack}, 32'h1);
    check("r_selected", {31'h0, selected}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      read_byte(d);
      w = {w[23:0], d};
    end
    if (fifth) begin
      read_byte(d);
      check("r_fifth_ff", {24'h0, d}, 32'hFF);
    end
    pulse_stop;
  endtask

  task automatic write_stream(input bytes_t data);
    int unsigned i, w, last;
    logic ack;
    i = 0; w = 0; last = 0;
    pulse_start;
    send_byte(8'h54, ack); check("s_addr_ack", {31'h0, ack}, 32'h1);
    send_byte(8'h01, ack); check("s_cmd_ack", {31'h0, ack}, 32'h1);
    @(negedge clk); rx_valid = 1'b1; rx_data = data[0];
    while (i < data.size() && w < 200) begin
      #1;
      if (rx_ready) begin
        if (i > 0) check("stream_gap", cyc - last, 32'd6);
        last = cyc;
        @(negedge clk);
        check("stream_ack", {31'h0, rx_ack}, 32'h1);
        i++;
        if (i < data.size()) rx_data = data[i];
        else rx_valid = 1'b0;
      end else begin
        @(negedge clk); w++;
      end
    end
    rx_valid = 1'b0;
    check("stream_done", i, data.size());
    wait_idle;
    pulse_stop;
    model_write(8'h01, data);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] h_new;
    logic [7:0]  d;
    logic        ack;
    int unsigned b0, t0, waited;
    bytes_t q;

    rst_n = 1'b0; evt_start = 1'b0; evt_stop = 1'b0;
    rx_valid = 1'b0; rx_data = '0; tx_req = 1'b0;
    m_hash = OFFSET; m_count = 0;
    repeat (3) @(negedge clk);
    check("rst_hash", hash_out, OFFSET);
    check("rst_count", {16'h0, byte_count}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_selected", {31'h0, selected}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("rst_rx_ack", {31'h0, rx_ack}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'hFF);
    rst_n = 1'b1;
    @(negedge clk);

    // RESET command then read back the offset basis.
    q = {};
    write_txn(8'h01, q);
    read_txn(1'b0, w);
    check("t1_read", w, 32'h811C9DC5);

    // Single byte "a", busy window and counter.
    q = {8'h61};
    b0 = busy_cycles;
    write_txn(8'h01, q);
    check("a_busy_cycles", busy_cycles - b0, 32'd6);
    check("a_hash", hash_out, 32'hE40C292C);
    check("a_count", {16'h0, byte_count}, 32'd1);
    read_txn(1'b0, w);
    check("a_read", w, 32'hE40C292C);

    // "foobar" with rx_valid held continuously.
    q = {8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    write_stream(q);
    read_txn(1'b1, w);
    check("foobar_read", w, 32'hBF9CF968);
    check("foobar_model", w, m_hash);
    check("foobar_count", {16'h0, byte_count}, 32'd6);

    // Address mismatch: everything NACKed, hash untouched.
    pulse_start;
    send_byte(8'h20, ack); check("mm_addr_nack", {31'h0, ack}, 32'h0);
    check("mm_selected", {31'h0, selected}, 32'h0);
    repeat (2) begin
      send_byte(8'($urandom), ack); check("mm_data_nack", {31'h0, ack}, 32'h0);
    end
    pulse_stop;
    check("mm_hash", hash_out, m_hash);

    // Bad command byte.
    pulse_start;
    send_byte(8'h54, ack); check("bc_addr_ack", {31'h0, ack}, 32'h1);
    send_byte(8'h07, ack); check("bc_cmd_nack", {31'h0, ack}, 32'h0);
    send_byte(8'h5A, ack); check("bc_data_nack", {31'h0, ack}, 32'h0);
    pulse_stop;
    check("bc_hash", hash_out, m_hash);
    check("bc_count", {16'h0, byte_count}, m_count);

    // Continuation: "a" then HASH with "b" gives FNV-1a("ab").
    q = {8'h61};
    write_txn(8'h01, q);
    q = {8'h62};
    write_txn(8'h02, q);
    check("ab_hash", hash_out, 32'h4D2505CA);
    check("ab_count", {16'h0, byte_count}, 32'd2);

    // Random transactions against the reference model.
    for (int n = 0; n < 6; n++) begin
      q = {};
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) q.push_back(8'($urandom));
      write_txn($urandom_range(0, 1) ? 8'h01 : 8'h02, q);
      read_txn(1'b0, w);
      check("rnd_read", w, m_hash);
      check("rnd_count", {16'h0, byte_count}, m_count);
    end

    // Repeated START into a read while a step is in flight.
    q = {8'h63};
    h_new = fnv1a_ref(m_hash, q);
    pulse_start;
    send_byte(8'h54, ack);
    send_byte(8'h02, ack);
    send_byte(8'h63, ack);
    pulse_start;
    send_byte(8'h55, ack); check("rs_addr_ack", {31'h0, ack}, 32'h1);
    tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
    check("rs_early", {31'h0, tx_valid}, 32'h0);
    waited = 0;
    while (!tx_valid && waited < 50) begin
      @(negedge clk); waited++;
    end
    check("rs_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("rs_committed", hash_out, h_new);
    check("rs_byte0", {24'h0, tx_data}, {24'h0, h_new[31:24]});
    w = {24'h0, tx_data};
    for (int k = 0; k < 3; k++) begin
      read_byte(d);
      w = {w[23:0], d};
    end
    check("rs_read", w, h_new);
    pulse_stop;
    model_write(8'h02, q);

    // Async reset on cycle 3 of a step.
    pulse_start;
    send_byte(8'h54, ack);
    send_byte(8'h02, ack);
    send_byte(8'h64, ack);
    @(negedge clk);
    @(negedge clk); #1;
    check("ar_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_hash", hash_out, OFFSET);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_count", {16'h0, byte_count}, 32'h0);
    check("ar_selected", {31'h0, selected}, 32'h0);
    check("ar_rx_ready", {31'h0, rx_ready}, 32'h0);
    t0 = tx_pulses;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("ar_no_tx", tx_pulses - t0, 32'd0);
    check("ar_hash_after", hash_out, OFFSET);
    m_hash = OFFSET; m_count = 0;
    read_txn(1'b0, w);
    check("ar_read", w, m_hash);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
